// File: rtl/spi_sequencer.sv
// spi_sequencer: byte-wide SPI master for the SBC PIO space.
// One host write starts an 8-bit MSB-first exchange in any CPOL/CPHA mode,
// with SCLK half-period H = 2^cfg_div clock cycles.
//
// state | meaning
// IDLE  | SCLK follows cfg_cpol, waiting for wr_data
// SHIFT | 16 SCLK edges, drive/sample MOSI/MISO per CPHA
// DONE  | publish rx_data, drop busy, set done, pulse irq
module spi_sequencer #(
  parameter int DIV_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_data,
  input  logic [7:0]       din,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic             status_clear,
  input  logic             spi_miso,
  output logic             spi_sclk,
  output logic             spi_mosi,
  output logic [7:0]       rx_data,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             irq
);

  // Wide enough to hold H-1 for the largest divider select.
  localparam int CNT_W = (1 << DIV_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] half_cnt;
  logic [4:0]       edge_cnt;
  logic [DIV_W-1:0] div_q;
  logic             cpha_q;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             half_tc;
  logic             last_edge;
  logic             lead_edge;
  logic             sample_edge;

  // Reload value H-1 = 2^d - 1, i.e. the low d bits set.
  function automatic logic [CNT_W-1:0] half_last(input logic [DIV_W-1:0] d);
    half_last = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i < int'(d)) half_last[i] = 1'b1;
    end
  endfunction

  // Half-period timer is a down-counter; terminal count at zero toggles SCLK.
  assign half_tc     = (half_cnt == '0);
  // edge_cnt holds edges already made, so the upcoming edge k = edge_cnt+1.
  assign last_edge   = (edge_cnt == 5'd15);
  assign lead_edge   = ~edge_cnt[0];
  // Leading edges sample for CPHA=0, trailing edges sample for CPHA=1.
  assign sample_edge = lead_edge ^ cpha_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_data) state_d = SHIFT;
      SHIFT:   if (half_tc && last_edge) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath, serial outputs and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b1;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      irq      <= 1'b0;
      half_cnt <= '0;
      edge_cnt <= '0;
      div_q    <= '0;
      cpha_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      irq <= 1'b0;
      case (state_q)
        IDLE: begin
          spi_sclk <= cfg_cpol;
          if (wr_data) begin
            busy     <= 1'b1;
            div_q    <= cfg_div;
            cpha_q   <= cfg_cpha;
            half_cnt <= half_last(cfg_div);
            edge_cnt <= '0;
            rx_sr    <= '0;
            if (!cfg_cpha) begin
              spi_mosi <= din[7];
              tx_sr    <= {din[6:0], 1'b0};
            end else begin
              tx_sr    <= din;
            end
          end
        end
        SHIFT: begin
          if (half_tc) begin
            half_cnt <= half_last(div_q);
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_cnt + 5'd1;
            if (sample_edge) begin
              rx_sr <= {rx_sr[6:0], spi_miso};
            end else if (!last_edge) begin
              spi_mosi <= tx_sr[7];
              tx_sr    <= {tx_sr[6:0], 1'b0};
            end
          end else begin
            half_cnt <= half_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          rx_data <= rx_sr;
          busy    <= 1'b0;
          irq     <= 1'b1;
        end
        default: ;
      endcase

      // Set events take priority over status_clear.
      if (state_q == DONE) done <= 1'b1;
      else if (status_clear) done <= 1'b0;

      if (wr_data && busy) overrun <= 1'b1;
      else if (status_clear) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_sequencer.sv
// tb_spi_sequencer: directed stimulus with a scoreboard of expected completions;
// a negedge monitor pops and compares on every irq and tracks SCLK/MOSI behaviour.
module tb_spi_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_data = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] cfg_div = 3'd0;
  logic       cfg_cpol = 1'b0;
  logic       cfg_cpha = 1'b0;
  logic       status_clear = 1'b0;
  logic       spi_miso;
  logic       spi_sclk, spi_mosi, busy, done, overrun, irq;
  logic [7:0] rx_data;

  logic       loop_en = 1'b1;
  logic [7:0] pat = 8'h00;
  logic       miso_drv = 1'b0;

  assign spi_miso = loop_en ? spi_mosi : miso_drv;

  spi_sequencer #(.DIV_W(3)) dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .din(din),
    .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .status_clear(status_clear), .spi_miso(spi_miso),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .rx_data(rx_data),
    .busy(busy), .done(done), .overrun(overrun), .irq(irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] rx;
    int         blen;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side view of the current transfer.
  bit   cpha_m = 1'b0;
  int   h_m = 1;
  int   ncyc = 0, rise_nc = 0, last_nc = 0;
  int   edge_seen = 0, first_off = 0, bad_sp = 0, mosi_viol = 0, busy_run = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic p_sclk = 1'b0, p_mosi = 1'b1, p_busy = 1'b0, p_irq = 1'b0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on irq, SCLK edge timing, MOSI legality, slave MISO.
  initial begin : monitor
    exp_t e;
    int   idx;
    bit   is_drive, allowed;
    forever begin
      @(negedge clock);
      ncyc++;
      if (reset) begin
        busy_run = 0;
      end else begin
        if (irq) begin
          chk_bit("irq_single_cycle", p_irq, 1'b0);
          if (exp_q.size() != 1) chk_int("scoreboard_depth", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_byte("rx_data", rx_data, e.rx);
            chk_bit("done_at_irq", done, 1'b1);
            chk_int("busy_cycles", busy_run, e.blen);
          end
        end
        if (busy) busy_run++;
        else busy_run = 0;

        if (busy && !p_busy) begin
          edge_seen = 0; rise_nc = ncyc; last_nc = ncyc;
          bad_sp = 0; first_off = -1; mosi_cap = 8'h00; mosi_viol = 0;
          if (cpha_m && (spi_mosi != p_mosi)) mosi_viol++;
        end else if (busy && (spi_sclk != p_sclk)) begin
          edge_seen++;
          if (edge_seen == 1) first_off = ncyc - rise_nc;
          else if (ncyc - last_nc != h_m) bad_sp++;
          last_nc  = ncyc;
          is_drive = cpha_m ? (edge_seen % 2 == 1) : (edge_seen % 2 == 0);
          allowed  = is_drive && !(!cpha_m && edge_seen == 16);
          if (!is_drive) mosi_cap = {mosi_cap[6:0], p_mosi};
          if (!allowed && (spi_mosi != p_mosi)) mosi_viol++;
        end else if (spi_mosi != p_mosi) begin
          mosi_viol++;
        end

        idx = cpha_m ? edge_seen / 2 : (edge_seen + 1) / 2;
        if (idx > 7) idx = 7;
        miso_drv = pat[7-idx];
      end
      p_sclk = spi_sclk; p_mosi = spi_mosi; p_busy = busy; p_irq = irq;
    end
  end

  task automatic do_write(input logic [7:0] d, input int div, input logic cpol,
                          input logic cpha, input bit push, input logic [7:0] rx_exp);
    exp_t e;
    @(posedge clock); #1;
    cfg_div = 3'(div); cfg_cpol = cpol; cfg_cpha = cpha;
    cpha_m = cpha; h_m = 1 << div;
    @(posedge clock); #1;
    wr_data = 1'b1; din = d;
    if (push) begin
      e.rx = rx_exp; e.blen = 16 * h_m + 1;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    wr_data = 1'b0;
  endtask

  task automatic wait_irq(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clock);
      if (irq) seen = 1'b1;
    end
    if (!seen) chk_bit("irq_timeout", irq, 1'b1);
  endtask

  task automatic post_checks(input logic [7:0] mosi_exp);
    chk_int("sclk_edges", edge_seen, 16);
    chk_int("first_edge_offset", first_off, h_m);
    chk_int("edge_spacing_errors", bad_sp, 0);
    chk_int("mosi_off_edge_changes", mosi_viol, 0);
    chk_byte("mosi_bits", mosi_cap, mosi_exp);
  endtask

  task automatic pulse_clear();
    @(posedge clock); #1 status_clear = 1'b1;
    @(posedge clock); #1 status_clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    chk_bit({tag, "_sclk"}, spi_sclk, 1'b0);
    chk_bit({tag, "_mosi"}, spi_mosi, 1'b1);
    chk_byte({tag, "_rx_data"}, rx_data, 8'h00);
    chk_bit({tag, "_busy"}, busy, 1'b0);
    chk_bit({tag, "_done"}, done, 1'b0);
    chk_bit({tag, "_overrun"}, overrun, 1'b0);
    chk_bit({tag, "_irq"}, irq, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit reached;

    // Reset values.
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset");
    @(posedge clock); #1 reset = 1'b0;

    // Mode 0, div 0, loopback 0xA5.
    loop_en = 1'b1;
    do_write(8'hA5, 0, 1'b0, 1'b0, 1'b1, 8'hA5);
    wait_irq(200);
    post_checks(8'hA5);
    repeat (2) @(negedge clock);
    chk_bit("irq_deasserted", irq, 1'b0);
    chk_bit("sclk_idle_mode0", spi_sclk, 1'b0);

    // Mode 3, div 2, slave returns 0x3C while master sends 0xC3.
    pulse_clear();
    loop_en = 1'b0; pat = 8'h3C;
    do_write(8'hC3, 2, 1'b1, 1'b1, 1'b1, 8'h3C);
    wait_irq(500);
    post_checks(8'hC3);
    repeat (2) @(negedge clock);
    chk_bit("sclk_idle_mode3", spi_sclk, 1'b1);
    repeat (3) @(negedge clock);
    chk_bit("done_sticky", done, 1'b1);
    pulse_clear();
    chk_bit("done_cleared", done, 1'b0);

    // Mode 1 and mode 2, div 1, loopback 0x81.
    loop_en = 1'b1;
    do_write(8'h81, 1, 1'b0, 1'b1, 1'b1, 8'h81);
    wait_irq(300);
    post_checks(8'h81);
    do_write(8'h81, 1, 1'b1, 1'b0, 1'b1, 8'h81);
    wait_irq(300);
    post_checks(8'h81);

    // Overrun 5 cycles in; status_clear coincident with completion.
    do_write(8'h3A, 0, 1'b0, 1'b0, 1'b1, 8'h3A);
    repeat (4) @(posedge clock);
    #1 wr_data = 1'b1; din = 8'hFF;
    @(posedge clock); #1 wr_data = 1'b0;
    @(negedge clock);
    chk_bit("overrun_set", overrun, 1'b1);
    repeat (11) @(posedge clock);
    #1 status_clear = 1'b1;
    @(posedge clock); #1 status_clear = 1'b0;
    wait_irq(50);
    chk_bit("overrun_after_clear", overrun, 1'b0);
    chk_bit("done_set_wins", done, 1'b1);
    post_checks(8'h3A);

    // Reset around edge 9 aborts; next transfer is clean.
    do_write(8'h96, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clock);
      if (edge_seen >= 9) reached = 1'b1;
    end
    if (!reached) chk_int("edge9_timeout", edge_seen, 9);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("abort");
    @(posedge clock); #1 reset = 1'b0;
    do_write(8'h5A, 0, 1'b0, 1'b0, 1'b1, 8'h5A);
    wait_irq(200);
    post_checks(8'h5A);

    // Back-to-back: write in the first cycle busy reads 0.
    do_write(8'h11, 0, 1'b0, 1'b0, 1'b1, 8'h11);
    wait_irq(200);
    chk_bit("b2b_busy_low", busy, 1'b0);
    post_checks(8'h11);
    wr_data = 1'b1; din = 8'hEE;
    begin
      exp_t e2;
      e2.rx = 8'hEE; e2.blen = 16 * h_m + 1;
      exp_q.push_back(e2);
    end
    @(posedge clock); #1 wr_data = 1'b0;
    @(negedge clock);
    chk_bit("b2b_started", busy, 1'b1);
    wait_irq(200);
    post_checks(8'hEE);
    chk_bit("b2b_no_overrun", overrun, 1'b0);

    repeat (3) @(negedge clock);
    chk_int("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sequencer.md
# spi_sequencer

Byte-wide SPI master sequencer for the SBC glue logic's PIO space. It takes one byte per host write, generates SCLK at a programmable divided rate in any of the four CPOL/CPHA modes, and shifts MOSI out MSB-first while capturing MISO. It reports busy, done, overrun and a one-cycle completion interrupt to the status and interrupt-controller logic. It replaces the free-running clock mux and shift-register arrangement with a single clocked controller.

## Interface

- `DIV_W`, default 3: width of the divider select; half-period H = 2^cfg_div clock cycles, so 1..128 cycles.
- `clock` in 1: system clock (x8m, 8 MHz).
- `reset` in 1: synchronous, active-high reset. Sampled on the rising edge of `clock`.
- `wr_data` in 1: one-cycle host write pulse (from write-strobe edge detector); loads `din` and starts a transfer.
- `din` in 8: transmit byte, sampled when `wr_data`=1.
- `cfg_div` in DIV_W: rate select, sampled at start.
- `cfg_cpol` in 1: SCLK idle level. Live in IDLE; latched at start.
- `cfg_cpha` in 1: phase select, latched at start.
- `status_clear` in 1: one-cycle pulse; clears `done` and `overrun`.
- `spi_miso` in 1: serial input, already synchronous to `clock`.
- `spi_sclk` out 1: serial clock.
- `spi_mosi` out 1: serial output.
- `rx_data` out 8: last received byte.
- `busy` out 1: transfer in progress.
- `done` out 1: sticky completion flag.
- `overrun` out 1: sticky flag; set when a write arrives while busy.
- `irq` out 1: one-cycle completion pulse to the interrupt controller.

## Operation

- Registered outputs only. Reset values:
  - `spi_sclk`=0, `spi_mosi`=1, `rx_data`=0x00
  - `busy`=0, `done`=0, `overrun`=0, `irq`=0
  - state=IDLE
- States and transitions:
  - IDLE: `spi_sclk` follows `cfg_cpol`. `wr_data` → SHIFT.
    - On entry to SHIFT: latch `din`, `cfg_div`, `cfg_cpol`, `cfg_cpha`; clear half-period counter and edge counter (5 bits, 0..16); set `busy`.
    - CPHA=0: `spi_mosi`=din[7] in the same update.
  - SHIFT: the half-period counter counts 0..H-1. At terminal count, toggle SCLK and increment the edge counter (k=1..16).
    - Odd k (leading edges): CPHA=0 samples MISO into the shift-register LSB; CPHA=1 drives the next MSB onto MOSI.
    - Even k (trailing edges): CPHA=0 drives the next MSB onto MOSI (none after k=16); CPHA=1 samples MISO.
    - After k=16, SCLK equals the latched CPOL → DONE.
  - DONE (1 cycle): `rx_data`←shift register, `busy`=0, `done`=1, `irq`=1 → IDLE.
- MOSI holds its last driven bit in IDLE.
- Config changes during SHIFT have no effect until the next start.
- `wr_data` while `busy`=1 (SHIFT or DONE): ignored, no data loaded, `overrun`←1.
- `status_clear` coincident with a set event (completion or overrun): set wins.
- `reset` mid-transfer: immediate abort to reset values; partial `rx_data` is discarded.

## Timing

- `wr_data` at cycle T → `busy`=1 at T+1.
- SCLK edge k occurs at T+1+k·H.
- `busy`=0, `done`=1, `irq`=1 and `rx_data` valid at T+2+16H.
- `irq` deasserts at T+3+16H.
- Example: div=0 gives busy high for 16H+1 = 17 cycles.
- A `wr_data` in the cycle `busy` first reads 0 starts a new transfer with no gap penalty.
- SCLK duty cycle is exactly 50%, period 2H cycles. At 8 MHz: div=0 → 4 MHz SCLK, div=7 → 31.25 kHz.
- MISO is sampled from the value present at the clock edge where SCLK toggles.

## Test plan

- Mode 0, div=0, MOSI looped to MISO, write 0xA5 → MOSI sequence 1,0,1,0,0,1,0,1; `rx_data`=0xA5; `busy` high exactly 17 cycles; single `irq` pulse; SCLK idles 0.
- Mode 3, div=2, MISO driven with pattern 0x3C → 16 SCLK edges, 4 cycles apart, idle high; `rx_data`=0x3C; `done`=1 until `status_clear`.
- Mode 1 and mode 2 with div=1, loopback 0x81 → `rx_data`=0x81; MOSI changes only on the specified edges (checked by assertion).
- Second `wr_data` 5 cycles into a transfer → `overrun`=1; first byte completes unchanged. `status_clear` coincident with completion → `done`=1 and `overrun`=0 afterward.
- `reset` asserted at edge 9 → next cycle all outputs at reset values; a following 0x5A transfer completes correctly.
- `wr_data` issued in the first cycle `busy`=0 after a transfer → new transfer starts; `overrun` stays 0.
